// File: rtl/bl_frame_sched.sv
// rtl/bl_frame_sched.sv - backlight frame scheduler: SDBP pulse plus one grey word per LED each refresh period
// Optional running-light test pattern for mode 2 is built when BL_TESTPAT_EN is defined.
module bl_frame_sched #(
    parameter int LED_NUM     = 360,
    parameter int PERIOD      = 35000,
    parameter int CFG_WAIT    = 2500,
    parameter int SDBP_HI     = 30,
    parameter int STEP_FRAMES = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] als_gain,
    output logic [9:0]  zone_rd_addr,
    input  logic [7:0]  zone_rd_data,
    output logic        sdbp_flag,
    output logic [9:0]  wt_addr,
    output logic [15:0] wt_data,
    output logic        wt_valid,
    input  logic        wt_ready,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);
    localparam int PW = $clog2(PERIOD + 1);
    localparam int CW = $clog2(CFG_WAIT + 1);
    localparam int SW = $clog2(SDBP_HI + 1);

    typedef enum logic [2:0] {
        S_CFG,
        S_IDLE,
        S_SDBP,
        S_RD,
        S_CALC,
        S_WR
    } state_t;

    state_t         state;
    logic [PW-1:0]  pcnt;
    logic [CW-1:0]  cfg_cnt;
    logic [SW-1:0]  sdbp_cnt;
    logic [9:0]     n;
    logic [1:0]     mode_l;
    logic [15:0]    gain_l;
    logic           boundary;
    logic           last_word;
    logic           word_accept;
    logic [16:0]    gain_plus;
    logic [33:0]    prod;
    logic [33:0]    quot;
    logic [15:0]    als_word;
    logic [15:0]    word;

    assign boundary    = (pcnt == '0) && (state != S_CFG);
    assign last_word   = (n == 10'(LED_NUM - 1));
    assign word_accept = (state == S_WR) && wt_ready;

    // g*256*(gain+20) peaks just under 2^32, so 34 bits never wrap before the divide.
    assign gain_plus = {1'b0, gain_l} + 17'd20;
    assign prod      = ({26'd0, zone_rd_data} * {17'd0, gain_plus}) << 8;
    assign quot      = prod / 34'd655;
    assign als_word  = (quot > 34'd65535) ? 16'hFFFF : quot[15:0];

`ifdef BL_TESTPAT_EN
    localparam int FW = $clog2(STEP_FRAMES + 1);
    logic [9:0]    tp_pos;
    logic [FW-1:0] tp_frames;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_pos    <= '0;
            tp_frames <= '0;
        end else if (word_accept && last_word) begin
            if (tp_frames == FW'(STEP_FRAMES - 1)) begin
                tp_frames <= '0;
                tp_pos    <= (tp_pos == 10'(LED_NUM - 1)) ? 10'd0 : tp_pos + 10'd1;
            end else begin
                tp_frames <= tp_frames + FW'(1);
            end
        end
    end
`else
    if (STEP_FRAMES < 1) begin : g_step_unused
    end
`endif

    always_comb begin
        word = 16'hFFFF;
        case (mode_l)
            2'd1: word = als_word;
`ifdef BL_TESTPAT_EN
            2'd2: word = (n == tp_pos) ? 16'hFFFF : 16'h0000;
`else
            2'd2: word = 16'hFFFF;
`endif
            2'd3: word = 16'h0000;
            default: word = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (state == S_CFG || pcnt == PW'(PERIOD - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_CFG;
            cfg_cnt      <= '0;
            sdbp_cnt     <= '0;
            n            <= '0;
            mode_l       <= '0;
            gain_l       <= '0;
            zone_rd_addr <= '0;
            sdbp_flag    <= 1'b0;
            wt_addr      <= '0;
            wt_data      <= '0;
            wt_valid     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A boundary landing mid-frame is dropped; IDLE waits for the next one.
            if (boundary && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_CFG: begin
                    if (cfg_cnt == CW'(CFG_WAIT - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        cfg_cnt <= cfg_cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (boundary && en) begin
                        mode_l    <= mode;
                        gain_l    <= als_gain;
                        n         <= '0;
                        sdbp_cnt  <= '0;
                        sdbp_flag <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_SDBP;
                    end
                end
                S_SDBP: begin
                    if (sdbp_cnt == SW'(SDBP_HI - 1)) begin
                        sdbp_flag    <= 1'b0;
                        zone_rd_addr <= n;
                        state        <= S_RD;
                    end else begin
                        sdbp_cnt <= sdbp_cnt + SW'(1);
                    end
                end
                S_RD: begin
                    state <= S_CALC;
                end
                S_CALC: begin
                    wt_data  <= word;
                    wt_addr  <= n;
                    wt_valid <= 1'b1;
                    state    <= S_WR;
                end
                S_WR: begin
                    if (wt_ready) begin
                        wt_valid <= 1'b0;
                        if (last_word) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            n            <= n + 10'd1;
                            zone_rd_addr <= n + 10'd1;
                            state        <= S_RD;
                        end
                    end
                end
                default: state <= S_CFG;
            endcase
        end
    end
endmodule

// File: tb/tb_bl_frame_sched.sv
// tb/tb_bl_frame_sched.sv - directed self-checking bench for bl_frame_sched with shortened timing parameters
module tb_bl_frame_sched;
    localparam int LN   = 24;
    localparam int PER  = 200;
    localparam int CW   = 50;
    localparam int SH   = 5;
    localparam int STEP = 3;
`ifdef BL_TESTPAT_EN
    localparam int NTP = 70;
`else
    localparam int NTP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] als_gain = 16'd0;
    logic [9:0]  zone_rd_addr;
    logic [7:0]  zone_rd_data = 8'd0;
    logic        sdbp_flag;
    logic [9:0]  wt_addr;
    logic [15:0] wt_data;
    logic        wt_valid;
    logic        wt_ready = 1'b1;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    bl_frame_sched #(
        .LED_NUM(LN), .PERIOD(PER), .CFG_WAIT(CW), .SDBP_HI(SH), .STEP_FRAMES(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .als_gain(als_gain),
        .zone_rd_addr(zone_rd_addr), .zone_rd_data(zone_rd_data),
        .sdbp_flag(sdbp_flag), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .frame_done(frame_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    longint      cyc = 0;
    longint      rises[$];
    int          fd_cnt = 0;
    logic        sd_prev = 1'b0;
    logic [9:0]  sb_a[$];
    logic [15:0] sb_d[$];

    function automatic logic [7:0] ram_g(input logic [9:0] a);
        logic [15:0] t;
        case (a)
            10'd1:   return 8'd100;
            10'd2:   return 8'd255;
            10'd3:   return 8'd200;
            default: begin
                t = {6'd0, a} * 16'd37 + 16'd11;
                return t[7:0];
            end
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int m, input int gain, input int addr, input int p);
        longint v;
        case (m)
            1: begin
                v = longint'(ram_g(10'(addr))) * 256 * (gain + 20) / 655;
                return (v > 65535) ? 16'hFFFF : 16'(v);
            end
`ifdef BL_TESTPAT_EN
            2: return (addr == p) ? 16'hFFFF : 16'h0000;
`endif
            3: return 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        zone_rd_data <= ram_g(zone_rd_addr);
        if (rst_n && wt_valid && wt_ready) begin
            sb_a.push_back(wt_addr);
            sb_d.push_back(wt_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (sdbp_flag && !sd_prev) rises.push_back(cyc);
        sd_prev = sdbp_flag;
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(input string tag, input int limit);
        int base;
        int k;
        base = rises.size();
        k = 0;
        while (rises.size() == base && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_start"}, 64'(rises.size()), 64'(base + 1));
        sb_a.delete();
        sb_d.delete();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 64'(frame_done), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int m, input int gain, input int p);
        int bad;
        bad = 0;
        for (int i = 0; i < sb_a.size(); i++) begin
            if (sb_a[i] !== 10'(i) || sb_d[i] !== exp_word(m, gain, i, p)) bad++;
        end
        chk({tag, "_count"}, 64'(sb_a.size()), 64'(LN));
        chk({tag, "_words"}, 64'(bad), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({sdbp_flag, wt_valid, wt_addr, wt_data, zone_rd_addr, frame_done, busy, overrun});
    endfunction

    initial begin
        longint c0;
        longint r0;
        int     nr;
        int     k;
        int     bad;
        int     p;
        logic [15:0] d0;
        logic [9:0]  a0;

        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        c0 = cyc;

        wait_rise("f1", 200);
        chk("cfg_wait_latency", 64'(rises[rises.size()-1] - c0), 64'(CW + 1));
        chk("busy_in_sdbp", 64'(busy), 64'd1);
        k = 0;
        while (sdbp_flag === 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("sdbp_width", 64'(k), 64'(SH));
        wait_done("f1", 500);
        chk("busy_at_done", 64'(busy), 64'd0);
        check_frame("f1", 0, 0, 0);
        @(negedge clk);
        chk("frame_done_pulse", 64'(frame_done), 64'd0);
        chk("frame_done_count", 64'(fd_cnt), 64'd1);

        mode = 2'd1;
        als_gain = 16'd635;
        wait_rise("f2", 300);
        chk("period", 64'(rises[rises.size()-1] - rises[rises.size()-2]), 64'(PER));
        wait_done("f2", 300);
        check_frame("f2", 1, 635, 0);
        chk("g100", 64'(sb_d[1]), 64'd25600);
        chk("g255", 64'(sb_d[2]), 64'd65280);

        als_gain = 16'd2000;
        wait_rise("f3", 300);
        wait_done("f3", 300);
        check_frame("f3", 1, 2000, 0);
        chk("g200_sat", 64'(sb_d[3]), 64'h0000_0000_0000_FFFF);

        als_gain = 16'd635;
        wait_rise("bp", 300);
        k = 0;
        while (!(wt_valid === 1'b1 && wt_addr === 10'd17) && k < 200) begin
            @(negedge clk);
            k++;
        end
        wt_ready = 1'b0;
        a0 = wt_addr;
        d0 = wt_data;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (wt_valid !== 1'b1 || wt_addr !== 10'd17 || wt_data !== d0) bad++;
        end
        chk("stall_addr", 64'(a0), 64'd17);
        chk("stall_data", 64'(d0), 64'd32768);
        chk("stall_hold", 64'(bad), 64'd0);
        wt_ready = 1'b1;
        wait_done("bp", 300);
        check_frame("bp", 1, 635, 0);

        mode = 2'd2;
        for (int f = 0; f < NTP; f++) begin
            p = (fd_cnt / STEP) % LN;
            wait_rise("tp", 300);
            wait_done("tp", 300);
            check_frame("tp", 2, 0, p);
        end

        mode = 2'd0;
        chk("overrun_clear", 64'(overrun), 64'd0);
        wt_ready = 1'b0;
        wait_rise("ov", 300);
        r0 = rises[rises.size()-1];
        nr = rises.size();
        repeat (300) @(negedge clk);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("no_start_while_busy", 64'(rises.size()), 64'(nr));
        wt_ready = 1'b1;
        wait_done("ov", 200);
        check_frame("ov", 0, 0, 0);
        wait_rise("ov_next", 500);
        chk("skip_one_start", 64'(rises[rises.size()-1] - r0), 64'(2 * PER));
        chk("overrun_sticky", 64'(overrun), 64'd1);

        k = 0;
        while (!(wt_valid === 1'b1 && wt_addr === 10'd10) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_word10", 64'(wt_addr), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        wait_rise("rst", 200);
        chk("cfg_wait_repeat", 64'(rises[rises.size()-1] - c0), 64'(CW + 1));
        wait_done("rst", 300);
        check_frame("rst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
